// File: rtl/idma_pkg.sv
// Shared definitions for the iDMA burst schedulers: 4 KB boundary,
// scheduler state encoding and beat-size helper.
package idma_pkg;

  localparam int unsigned BOUNDARY_BITS  = 12;
  localparam int unsigned BOUNDARY_BYTES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // AXI size code (log2 of bytes per beat) for a given data width.
  function automatic int unsigned size_of(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/idma_rd_burst_sched_if.sv
// Command, master read user port, read-beat stream and status signals of
// the read burst scheduler.
interface idma_rd_burst_sched_if #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned BYTES_WIDTH = 24
) ();

  logic                   cmd_valid_i;
  logic                   cmd_ready_o;
  logic [ADDR_WIDTH-1:0]  cmd_addr_i;
  logic [BYTES_WIDTH-1:0] cmd_bytes_i;
  logic [ID_WIDTH-1:0]    cmd_id_i;

  logic                   m_r_cen_o;
  logic [ADDR_WIDTH-1:0]  m_r_addr_o;
  logic [2:0]             m_r_size_o;
  logic [7:0]             m_r_len_o;
  logic [ID_WIDTH-1:0]    m_r_id_o;
  logic                   m_r_ready_i;
  logic [DATA_WIDTH-1:0]  m_r_rdata_i;
  logic                   m_r_rvalid_i;

  logic                   dout_valid_o;
  logic [DATA_WIDTH-1:0]  dout_data_o;
  logic                   dout_last_o;
  logic                   done_o;
  logic                   busy_o;
  logic                   err_o;

  // Scheduler side.
  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_bytes_i, cmd_id_i,
    input  m_r_ready_i, m_r_rdata_i, m_r_rvalid_i,
    output cmd_ready_o,
    output m_r_cen_o, m_r_addr_o, m_r_size_o, m_r_len_o, m_r_id_o,
    output dout_valid_o, dout_data_o, dout_last_o, done_o, busy_o, err_o
  );

  // Command source / AXI master / beat consumer side.
  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_bytes_i, cmd_id_i,
    output m_r_ready_i, m_r_rdata_i, m_r_rvalid_i,
    input  cmd_ready_o,
    input  m_r_cen_o, m_r_addr_o, m_r_size_o, m_r_len_o, m_r_id_o,
    input  dout_valid_o, dout_data_o, dout_last_o, done_o, busy_o, err_o
  );

endinterface

// File: rtl/idma_burst_calc.sv
// Next burst length in beats: min(beats remaining, MAX_BURST_LEN, beats to
// the next 4 KB boundary), saturated to the AXI limit of 256.
module idma_burst_calc
  import idma_pkg::*;
#(
  parameter int unsigned REM_WIDTH     = 21,
  parameter int unsigned MAX_BURST_LEN = 16,
  parameter int unsigned SIZE          = 3
) (
  input  logic [REM_WIDTH-1:0]     i_beats_rem,
  input  logic [BOUNDARY_BITS-1:0] i_addr_lo,
  output logic [8:0]               o_burst_c
);

  localparam int unsigned BW4K  = BOUNDARY_BITS + 1;
  localparam logic [8:0]  MAX_B = 9'(MAX_BURST_LEN);

  logic [BW4K-1:0] w_beats_4k;
  logic [8:0]      w_rem_sat;
  logic [8:0]      w_4k_sat;
  logic [8:0]      w_min_a;

  always_comb begin
    w_beats_4k = (BW4K'(BOUNDARY_BYTES) - BW4K'(i_addr_lo)) >> SIZE;
    w_rem_sat  = (32'(i_beats_rem) > 32'd256) ? 9'd256 : 9'(i_beats_rem);
    w_4k_sat   = (w_beats_4k > BW4K'(256)) ? 9'd256 : 9'(w_beats_4k);
    w_min_a    = (w_rem_sat < MAX_B) ? w_rem_sat : MAX_B;
    o_burst_c  = (w_4k_sat < w_min_a) ? w_4k_sat : w_min_a;
  end

endmodule

// File: rtl/idma_rd_burst_sched.sv
// Read-side burst scheduler: splits one DMA read command into INCR bursts
// on the master user port and forwards returned beats with a command-last flag.
module idma_rd_burst_sched
  import idma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 64,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned BYTES_WIDTH   = 24,
  parameter int unsigned MAX_BURST_LEN = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  idma_rd_burst_sched_if.master bus
);

  localparam int unsigned SIZE       = size_of(DATA_WIDTH);
  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
  localparam int unsigned REM_WIDTH  = BYTES_WIDTH - SIZE;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [ADDR_WIDTH-1:0]  r_m_addr;
  logic [7:0]             r_len;
  logic [ID_WIDTH-1:0]    r_id;
  logic [REM_WIDTH-1:0]   r_beats_rem;
  logic [8:0]             r_burst;
  logic [8:0]             r_beat_cnt;
  logic                   r_err;

  logic [8:0] w_burst_c;
  logic       w_misalign;
  logic       w_bad_cmd;
  logic       w_accept;
  logic       w_beat;
  logic       w_burst_end;
  logic       w_rem_last;
  logic       w_last;
  logic       w_cmd_ready;
  logic       w_cen;
  logic       w_busy;
  logic       w_done;

  idma_burst_calc #(
    .REM_WIDTH     (REM_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN),
    .SIZE          (SIZE)
  ) u_burst_calc (
    .i_beats_rem (r_beats_rem),
    .i_addr_lo   (r_addr[BOUNDARY_BITS-1:0]),
    .o_burst_c   (w_burst_c)
  );

  always_comb begin
    w_misalign = ((bus.cmd_addr_i & ADDR_WIDTH'(BEAT_BYTES - 1)) != '0) ||
                 ((bus.cmd_bytes_i & BYTES_WIDTH'(BEAT_BYTES - 1)) != '0);
    w_bad_cmd  = (bus.cmd_bytes_i == '0) || w_misalign;
    w_rem_last = (r_beats_rem == REM_WIDTH'(r_burst));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_cen       = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    w_beat      = 1'b0;
    w_burst_end = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy      = 1'b0;
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = w_bad_cmd ? ST_FIN : ST_CALC;
        end
      end
      ST_CALC: w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        w_cen  = 1'b1;
        w_beat = bus.m_r_rvalid_i;
        w_last = bus.m_r_rvalid_i && w_rem_last && (r_beat_cnt == r_burst - 9'd1);
        if (bus.m_r_ready_i) begin
          w_burst_end = 1'b1;
          w_state_nxt = w_rem_last ? ST_FIN : ST_CALC;
        end
      end
      ST_FIN: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Command/burst datapath; the address wraps at 2^ADDR_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_m_addr    <= '0;
      r_len       <= '0;
      r_id        <= '0;
      r_beats_rem <= '0;
      r_burst     <= '0;
      r_beat_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr      <= bus.cmd_addr_i;
        r_id        <= bus.cmd_id_i;
        r_beats_rem <= REM_WIDTH'(bus.cmd_bytes_i >> SIZE);
        r_err       <= w_misalign;
      end
      if (r_state == ST_CALC) begin
        r_burst    <= w_burst_c;
        r_len      <= 8'(w_burst_c - 9'd1);
        r_m_addr   <= r_addr;
        r_beat_cnt <= '0;
      end
      if (w_beat) r_beat_cnt <= r_beat_cnt + 9'd1;
      if (w_burst_end) begin
        if ((r_beat_cnt + 9'd1) != r_burst) r_err <= 1'b1;
        r_addr      <= r_addr + (ADDR_WIDTH'(r_burst) << SIZE);
        r_beats_rem <= r_beats_rem - REM_WIDTH'(r_burst);
      end
    end
  end

  assign bus.cmd_ready_o  = w_cmd_ready;
  assign bus.m_r_cen_o    = w_cen;
  assign bus.m_r_addr_o   = r_m_addr;
  assign bus.m_r_size_o   = 3'(SIZE);
  assign bus.m_r_len_o    = r_len;
  assign bus.m_r_id_o     = r_id;
  assign bus.dout_valid_o = w_beat;
  assign bus.dout_data_o  = w_beat ? bus.m_r_rdata_i : '0;
  assign bus.dout_last_o  = w_last;
  assign bus.done_o       = w_done;
  assign bus.busy_o       = w_busy;
  assign bus.err_o        = r_err;

endmodule

// File: tb/tb_idma_rd_burst_sched.sv
// Directed bench for idma_rd_burst_sched with a simple AXI read-master model.
module tb_idma_rd_burst_sched;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned BW = 24;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  idma_rd_burst_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BYTES_WIDTH(BW)) bus ();

  idma_rd_burst_sched #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BYTES_WIDTH(BW), .MAX_BURST_LEN(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;

  logic [AW-1:0] log_addr [8];
  logic [7:0]    log_len  [8];
  logic [IW-1:0] log_id   [8];
  logic [2:0]    log_size [8];
  int            log_n, stab_err, short_beats;
  logic          stray_rv;
  logic [DW-1:0] data_seq;
  int mon_beats, mon_last_n, mon_last_idx, mon_done, mon_cen, mon_pass_err, mon_rdy_busy;

  // Read-master model: per cen burst, 2-cycle AR latency then len+1 beats, ready on last.
  initial begin : slave_model
    logic [AW-1:0] a;
    logic [7:0]    l;
    logic [IW-1:0] id;
    int            n;
    bus.m_r_rvalid_i = 1'b0;
    bus.m_r_ready_i  = 1'b0;
    bus.m_r_rdata_i  = '0;
    data_seq = 64'hC0DE_0000_0000_0000;
    forever begin
      @(negedge clk);
      bus.m_r_rvalid_i = 1'b0;
      bus.m_r_ready_i  = 1'b0;
      bus.m_r_rdata_i  = '0;
      if (rst_n === 1'b1 && bus.m_r_cen_o === 1'b1) begin
        a = bus.m_r_addr_o; l = bus.m_r_len_o; id = bus.m_r_id_o;
        if (log_n < 8) begin
          log_addr[log_n] = a; log_len[log_n] = l; log_id[log_n] = id;
          log_size[log_n] = bus.m_r_size_o;
        end
        log_n++;
        n = (short_beats != 0) ? short_beats : int'(l) + 1;
        short_beats = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < n; k++) begin
          if (rst_n !== 1'b1) break;
          if (bus.m_r_addr_o !== a || bus.m_r_len_o !== l || bus.m_r_id_o !== id ||
              bus.m_r_cen_o !== 1'b1) stab_err++;
          data_seq         = data_seq + 64'h1_0001;
          bus.m_r_rvalid_i = 1'b1;
          bus.m_r_rdata_i  = data_seq;
          bus.m_r_ready_i  = (k == n - 1);
          @(negedge clk);
        end
        bus.m_r_rvalid_i = 1'b0;
        bus.m_r_ready_i  = 1'b0;
        bus.m_r_rdata_i  = '0;
      end else begin
        bus.m_r_rvalid_i = stray_rv;
      end
    end
  end

  // Output monitor, sampled mid-cycle.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1) begin
        if (bus.dout_valid_o) begin
          mon_beats++;
          if (bus.dout_data_o !== bus.m_r_rdata_i) mon_pass_err++;
          if (bus.dout_last_o) begin
            mon_last_n++;
            mon_last_idx = mon_beats;
          end
        end
        if (bus.dout_valid_o !== (bus.m_r_rvalid_i && bus.m_r_cen_o)) mon_pass_err++;
        if (bus.done_o) mon_done++;
        if (bus.m_r_cen_o) mon_cen++;
        if (bus.busy_o && bus.cmd_ready_o) mon_rdy_busy++;
      end
    end
  end

  task automatic clear_mon();
    mon_beats = 0; mon_last_n = 0; mon_last_idx = 0; mon_done = 0; mon_cen = 0;
    mon_pass_err = 0; mon_rdy_busy = 0; log_n = 0; stab_err = 0;
  endtask

  // Issue one command from IDLE and wait for done; cyc = cycles from accept to done.
  task automatic run_cmd(input logic [AW-1:0] addr, input logic [BW-1:0] bytes,
                         input logic [IW-1:0] id, output int cyc);
    clear_mon();
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_addr_i = addr; bus.cmd_bytes_i = bytes; bus.cmd_id_i = id;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      #3;
      cyc++;
    end while (mon_done == 0 && cyc < 300);
    repeat (3) @(negedge clk);
    #3;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid_i = 1'b0; bus.cmd_addr_i = '0; bus.cmd_bytes_i = '0; bus.cmd_id_i = '0;
    stray_rv = 1'b0; short_beats = 0;
    clear_mon();
    repeat (2) @(negedge clk);
    #3;
    total++;
    if ({bus.m_r_cen_o, bus.dout_valid_o, bus.dout_last_o, bus.done_o, bus.busy_o, bus.err_o} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {bus.m_r_cen_o, bus.dout_valid_o,
               bus.dout_last_o, bus.done_o, bus.busy_o, bus.err_o});
    else passed++;
    total++;
    if (bus.m_r_addr_o !== '0 || bus.m_r_len_o !== 8'd0 || bus.m_r_id_o !== '0)
      $display("FAIL reset_port: addr %h len %h id %h want 0", bus.m_r_addr_o, bus.m_r_len_o, bus.m_r_id_o);
    else passed++;
    total++;
    if (bus.cmd_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.cmd_ready_o);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_burst();
    int cyc;
    run_cmd(64'h1000, 24'd128, 4'h5, cyc);
    total++;
    if (log_n !== 1 || log_addr[0] !== 64'h1000 || log_len[0] !== 8'd15)
      $display("FAIL single_burst: n %0d addr %h len %0d want 1 1000 15", log_n, log_addr[0], log_len[0]);
    else passed++;
    total++;
    if (log_size[0] !== 3'd3 || log_id[0] !== 4'h5)
      $display("FAIL single_size_id: size %0d id %h want 3 5", log_size[0], log_id[0]);
    else passed++;
    total++;
    if (mon_beats !== 16 || mon_last_n !== 1 || mon_last_idx !== 16)
      $display("FAIL single_beats: beats %0d lasts %0d last_at %0d want 16 1 16", mon_beats, mon_last_n, mon_last_idx);
    else passed++;
    total++;
    if (mon_done !== 1 || bus.err_o !== 1'b0 || mon_pass_err !== 0 || stab_err !== 0)
      $display("FAIL single_done: done %0d err %b pass_err %0d stab %0d want 1 0 0 0",
               mon_done, bus.err_o, mon_pass_err, stab_err);
    else passed++;
  endtask

  task automatic test_two_bursts();
    int cyc;
    run_cmd(64'h1000, 24'd200, 4'h3, cyc);
    total++;
    if (log_n !== 2 || log_addr[0] !== 64'h1000 || log_len[0] !== 8'd15 ||
        log_addr[1] !== 64'h1080 || log_len[1] !== 8'd8)
      $display("FAIL two_bursts: n %0d %h/%0d %h/%0d want 2 1000/15 1080/8",
               log_n, log_addr[0], log_len[0], log_addr[1], log_len[1]);
    else passed++;
    total++;
    if (mon_beats !== 25 || mon_last_n !== 1 || mon_last_idx !== 25 || mon_done !== 1)
      $display("FAIL two_beats: beats %0d lasts %0d last_at %0d done %0d want 25 1 25 1",
               mon_beats, mon_last_n, mon_last_idx, mon_done);
    else passed++;
  endtask

  task automatic test_4k_split();
    int cyc;
    run_cmd(64'h0FC0, 24'd128, 4'hA, cyc);
    total++;
    if (log_n !== 2 || log_addr[0] !== 64'h0FC0 || log_len[0] !== 8'd7 ||
        log_addr[1] !== 64'h1000 || log_len[1] !== 8'd7)
      $display("FAIL split_4k: n %0d %h/%0d %h/%0d want 2 fc0/7 1000/7",
               log_n, log_addr[0], log_len[0], log_addr[1], log_len[1]);
    else passed++;
    total++;
    if (mon_beats !== 16 || mon_last_idx !== 16 || bus.err_o !== 1'b0 || stab_err !== 0)
      $display("FAIL split_beats: beats %0d last_at %0d err %b stab %0d want 16 16 0 0",
               mon_beats, mon_last_idx, bus.err_o, stab_err);
    else passed++;
  endtask

  task automatic test_no_burst();
    int cyc;
    run_cmd(64'h2000, 24'd0, 4'h1, cyc);
    total++;
    if (cyc > 2 || mon_done !== 1 || mon_cen !== 0 || bus.err_o !== 1'b0)
      $display("FAIL zero_bytes: cyc %0d done %0d cen %0d err %b want <=2 1 0 0", cyc, mon_done, mon_cen, bus.err_o);
    else passed++;
    run_cmd(64'h1004, 24'd64, 4'h1, cyc);
    total++;
    if (cyc > 2 || mon_done !== 1 || mon_cen !== 0 || bus.err_o !== 1'b1)
      $display("FAIL misalign_addr: cyc %0d done %0d cen %0d err %b want <=2 1 0 1", cyc, mon_done, mon_cen, bus.err_o);
    else passed++;
    run_cmd(64'h1000, 24'd60, 4'h1, cyc);
    total++;
    if (mon_done !== 1 || mon_cen !== 0 || bus.err_o !== 1'b1 || bus.busy_o !== 1'b0)
      $display("FAIL misalign_bytes: done %0d cen %0d err %b busy %b want 1 0 1 0", mon_done, mon_cen, bus.err_o, bus.busy_o);
    else passed++;
  endtask

  task automatic test_short_burst();
    int cyc;
    short_beats = 3;
    run_cmd(64'h6000, 24'd32, 4'h2, cyc);
    total++;
    if (log_len[0] !== 8'd3 || mon_beats !== 3 || mon_last_n !== 0 || mon_done !== 1 || bus.err_o !== 1'b1)
      $display("FAIL short_burst: len %0d beats %0d lasts %0d done %0d err %b want 3 3 0 1 1",
               log_len[0], mon_beats, mon_last_n, mon_done, bus.err_o);
    else passed++;
    run_cmd(64'h6000, 24'd32, 4'h2, cyc);
    total++;
    if (mon_beats !== 4 || mon_last_idx !== 4 || bus.err_o !== 1'b0)
      $display("FAIL err_clear: beats %0d last_at %0d err %b want 4 4 0", mon_beats, mon_last_idx, bus.err_o);
    else passed++;
  endtask

  task automatic test_stray_rvalid();
    clear_mon();
    @(negedge clk);
    stray_rv = 1'b1;
    repeat (3) @(negedge clk);
    stray_rv = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (mon_beats !== 0 || mon_pass_err !== 0)
      $display("FAIL stray_rvalid: beats %0d pass_err %0d want 0 0", mon_beats, mon_pass_err);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    clear_mon();
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_addr_i = 64'h3000; bus.cmd_bytes_i = 24'd64; bus.cmd_id_i = 4'h6;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_addr_i = 64'h4000; bus.cmd_id_i = 4'h7;
    cyc = 0;
    do begin @(negedge clk); #3; cyc++; end while (mon_done == 0 && cyc < 300);
    total++;
    if (bus.cmd_ready_o !== 1'b0 || mon_rdy_busy !== 0 || mon_done !== 1)
      $display("FAIL b2b_busy: ready %b rdy_busy %0d done %0d want 0 0 1", bus.cmd_ready_o, mon_rdy_busy, mon_done);
    else passed++;
    @(negedge clk);
    #3;
    total++;
    if (bus.cmd_ready_o !== 1'b1) $display("FAIL b2b_ready: got %b want 1", bus.cmd_ready_o);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    cyc = 0;
    do begin @(negedge clk); #3; cyc++; end while (mon_done < 2 && cyc < 300);
    total++;
    if (log_n !== 2 || log_addr[1] !== 64'h4000 || log_id[1] !== 4'h7 || log_id[0] !== 4'h6 ||
        mon_beats !== 16 || mon_done !== 2 || mon_rdy_busy !== 0)
      $display("FAIL b2b_second: n %0d addr %h id %h/%h beats %0d done %0d rdy_busy %0d want 2 4000 6/7 16 2 0",
               log_n, log_addr[1], log_id[0], log_id[1], mon_beats, mon_done, mon_rdy_busy);
    else passed++;
  endtask

  task automatic test_reset_mid_issue();
    int cyc;
    clear_mon();
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_addr_i = 64'h7000; bus.cmd_bytes_i = 24'd128; bus.cmd_id_i = 4'h4;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    cyc = 0;
    do begin @(negedge clk); #3; cyc++; end while (mon_beats < 3 && cyc < 100);
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    total++;
    if ({bus.m_r_cen_o, bus.dout_valid_o, bus.dout_last_o, bus.done_o, bus.busy_o, bus.err_o} !== 6'b0 ||
        bus.cmd_ready_o !== 1'b1 || bus.m_r_addr_o !== '0 || bus.m_r_len_o !== 8'd0)
      $display("FAIL mid_reset: ctrl %b ready %b addr %h len %0d want 000000 1 0 0",
               {bus.m_r_cen_o, bus.dout_valid_o, bus.dout_last_o, bus.done_o, bus.busy_o, bus.err_o},
               bus.cmd_ready_o, bus.m_r_addr_o, bus.m_r_len_o);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    total++;
    if (mon_done !== 0 || bus.cmd_ready_o !== 1'b1 || mon_beats < 3)
      $display("FAIL mid_reset_done: done %0d ready %b beats %0d want 0 1 >=3", mon_done, bus.cmd_ready_o, mon_beats);
    else passed++;
    run_cmd(64'h5000, 24'd64, 4'h9, cyc);
    total++;
    if (log_n !== 1 || log_addr[0] !== 64'h5000 || log_len[0] !== 8'd7 || log_id[0] !== 4'h9 ||
        mon_beats !== 8 || mon_last_idx !== 8 || mon_done !== 1 || bus.err_o !== 1'b0)
      $display("FAIL after_reset: n %0d addr %h len %0d id %h beats %0d last_at %0d done %0d err %b",
               log_n, log_addr[0], log_len[0], log_id[0], mon_beats, mon_last_idx, mon_done, bus.err_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_two_bursts();
    test_4k_split();
    test_no_burst();
    test_short_burst();
    test_stray_rvalid();
    test_back_to_back();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/idma_rd_burst_sched.md
Name: idma_rd_burst_sched

Overview:
Read-side burst scheduler for the iDMA AXI memory master. It accepts one DMA read command (base address, byte count, ID) and splits it into AXI INCR bursts. Each burst is capped at MAX_BURST_LEN beats and never crosses a 4 KB boundary. It drives the master's r_cen/r_addr/r_len/r_size/r_id user port and forwards the returned beats as a stream that marks the last beat of the whole command.

Parameters:
ADDR_WIDTH, 64, address width (matches master RW_ADDR_WIDTH)
DATA_WIDTH, 64, beat width in bits; BEAT_BYTES = DATA_WIDTH/8, SIZE = log2(BEAT_BYTES)
ID_WIDTH, 4, AXI ID width
BYTES_WIDTH, 24, width of the command byte count
MAX_BURST_LEN, 16, max beats per burst (1..256)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_addr_i  in  ADDR_WIDTH  start byte address
cmd_bytes_i  in  BYTES_WIDTH  total bytes
cmd_id_i  in  ID_WIDTH  AXI ID for all bursts
m_r_cen_o  out  1  to master r_cen_i
m_r_addr_o  out  ADDR_WIDTH  to master r_addr_i
m_r_size_o  out  3  to master r_size_i, constant SIZE
m_r_len_o  out  8  to master r_len_i (beats-1)
m_r_id_o  out  ID_WIDTH  to master r_id_i
m_r_ready_i  in  1  master r_ready_o (1-cycle pulse on last-beat handshake)
m_r_rdata_i  in  DATA_WIDTH  master r_rdata_o
m_r_rvalid_i  in  1  master r_rvalid_o
dout_valid_o  out  1  read beat valid (no backpressure)
dout_data_o  out  DATA_WIDTH  read beat
dout_last_o  out  1  last beat of the command
done_o  out  1  1-cycle pulse when command completes
busy_o  out  1  command in progress
err_o  out  1  sticky error; cleared on next accepted command

Behaviour:
- Reset values: all outputs 0 except cmd_ready_o=1. FSM returns to IDLE; master shares rst_n.
- States: IDLE, CALC, ISSUE, FIN.
- IDLE: cmd_ready_o=1. On accept: latch addr, id, beats_rem = bytes>>SIZE; clear err.
  - If bytes==0 or addr[SIZE-1:0]!=0 or bytes[SIZE-1:0]!=0: set err only in the misalignment cases, then go to FIN. No burst is issued.
  - Otherwise go to CALC.
- CALC (1 cycle): beats_4k = (4096 - addr[11:0]) >> SIZE; burst = min(beats_rem, MAX_BURST_LEN, beats_4k). Register m_r_len_o = burst-1 and m_r_addr_o = addr. Clear beat_cnt. Go to ISSUE.
- ISSUE: m_r_cen_o=1; addr/len/id held stable.
  - Each m_r_rvalid_i: dout_valid_o=dout_data_o passthrough (combinational); beat_cnt++.
  - dout_last_o = m_r_rvalid_i & (beats_rem==burst) & (beat_cnt==burst-1).
  - On m_r_ready_i: if beat_cnt+1 != burst, set err. Update addr += burst<<SIZE and beats_rem -= burst. Go to FIN if beats_rem becomes 0, else go to CALC.
- m_r_cen_o is 0 outside ISSUE, which parks the master in its DONE state. The next ISSUE walks the master DONE->IDLE->ADDR, so AR for the next burst appears 2 cycles after ISSUE entry.
- FIN: done_o=1 for one cycle, then go to IDLE. busy_o=1 in CALC/ISSUE/FIN. cmd_ready_o=0 outside IDLE.
- Arithmetic: beats_rem is BYTES_WIDTH-SIZE bits. Burst computation is 9-bit saturating (max 256). Address add wraps modulo 2^ADDR_WIDTH.
- rvalid outside ISSUE is ignored: no dout, no count.
- Reset mid-burst: immediate return to IDLE; no done_o; in-flight data dropped.

Decomposition:
- Shared package idma_pkg: 4 KB boundary constant (12 bits), state encoding, SIZE computed from DATA_WIDTH.
- One sub-module, idma_burst_calc: combinational min(beats_rem, MAX_BURST_LEN, beats_to_4k). It is reusable by the write-side scheduler.

Test Plan:
- addr 0x1000, bytes 128 -> one burst: addr 0x1000, len 15, size 3, id echoed; 16 dout beats, dout_last on beat 16; done_o 1 pulse; err 0.
- addr 0x1000, bytes 200 -> bursts (0x1000, len 15) then (0x1080, len 8); dout_last only on beat 25.
- addr 0x0FC0, bytes 128 -> 4 KB split: (0x0FC0, len 7) then (0x1000, len 7); no burst crosses 0x1000.
- bytes 0 at addr 0x2000 -> done_o 2 cycles after accept, m_r_cen_o never 1, err 0. addr 0x1004, bytes 64 -> err 1, done pulse, no cen.
- Slave returns 3 beats on a len-3 burst before last -> err set, command still completes; next command clears err.
- cmd_valid held during busy -> cmd_ready 0 until after done; assert rst_n low mid-ISSUE -> all outputs at reset values, cmd_ready 1 after release, new command runs cleanly.
